// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter for the RISC-V core.
// Holds the fetch PC and drives a valid/ready request to instruction memory.
// Next-PC sources are sequential advance, redirect, trap entry and trap return.
// A BOOT/RUN/HALT state machine provides debug halt and resume.
// A redirect to a misaligned target is turned into a trap entry.
module pc_unit #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]      TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned          ILEN_BYTES   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic            ret_valid,
    input  logic            halt_req,
    input  logic            resume_req,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic [XLEN-1:0] epc,
    output logic            misalign,
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Sequential increment and the low-order bits a legal target must keep at zero.
    localparam logic [XLEN-1:0] INC        = XLEN'(ILEN_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            misalign_q, misalign_d;
    logic            fetch_valid_q;
    logic            halted_q;

    logic            target_misaligned;
    logic            advance;

    assign pc_plus           = pc_q + INC;
    assign target_misaligned = (redirect_target & ALIGN_MASK) != '0;

    // The request is consumed only while running with no stall and no halt
    // arriving at the same edge.
    assign advance = (state_q == ST_RUN) && fetch_valid_q && fetch_ready
                     && !stall && !halt_req;

    // Next state: BOOT lasts one cycle, halt_req wins over resume_req in RUN.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt_req)   state_d = ST_HALT;
            ST_HALT: if (resume_req) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // Next PC by priority: trap > ret > redirect > stall > advance > hold.
    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        if (state_q != ST_BOOT) begin
            if (trap_valid) begin
                pc_d  = TRAP_VECTOR;
                epc_d = pc_q;
            end else if (ret_valid) begin
                pc_d = epc_q;
            end else if (redirect_valid) begin
                if (target_misaligned) begin
                    pc_d       = TRAP_VECTOR;
                    epc_d      = redirect_target;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = redirect_target;
                end
            end else if (!stall && advance) begin
                pc_d = pc_plus;
            end
        end
    end

    // State, PC registers and registered outputs; reset clears all of them at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            misalign_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            misalign_q    <= misalign_d;
            fetch_valid_q <= (state_d == ST_RUN);
            halted_q      <= (state_d == ST_HALT);
        end
    end

    assign pc          = pc_q;
    assign epc         = epc_q;
    assign misalign    = misalign_q;
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed test of pc_unit with hand-computed expected values.
// u_dut uses the default vectors; u_dut_hv uses a reset vector near the top
// of the address space to exercise increment wrap-around.
module tb_pc_unit;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            reset;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_valid;
    logic            ret_valid;
    logic            halt_req;
    logic            resume_req;
    logic            fetch_ready;
    logic            fetch_valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] epc;
    logic            misalign;
    logic            halted;

    logic            reset_hv;
    logic            fetch_valid_hv;
    logic [XLEN-1:0] pc_hv;
    logic [XLEN-1:0] pc_plus_hv;
    logic [XLEN-1:0] epc_hv;
    logic            misalign_hv;
    logic            halted_hv;

    int checks = 0;
    int errors = 0;

    pc_unit #(.XLEN(XLEN)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .ret_valid       (ret_valid),
        .halt_req        (halt_req),
        .resume_req      (resume_req),
        .fetch_ready     (fetch_ready),
        .fetch_valid     (fetch_valid),
        .pc              (pc),
        .pc_plus         (pc_plus),
        .epc             (epc),
        .misalign        (misalign),
        .halted          (halted)
    );

    pc_unit #(.XLEN(XLEN), .RESET_VECTOR(32'hFFFF_FFF8)) u_dut_hv (
        .clk             (clk),
        .reset           (reset_hv),
        .stall           (1'b0),
        .redirect_valid  (1'b0),
        .redirect_target ('0),
        .trap_valid      (1'b0),
        .ret_valid       (1'b0),
        .halt_req        (1'b0),
        .resume_req      (1'b0),
        .fetch_ready     (1'b1),
        .fetch_valid     (fetch_valid_hv),
        .pc              (pc_hv),
        .pc_plus         (pc_plus_hv),
        .epc             (epc_hv),
        .misalign        (misalign_hv),
        .halted          (halted_hv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle before sampling and driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        trap_valid     = 1'b0;
        ret_valid      = 1'b0;
        halt_req       = 1'b0;
        resume_req     = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        reset_hv        = 1'b1;
        redirect_target = '0;
        fetch_ready     = 1'b1;
        idle_inputs();

        step();
        step();
        check("rst_pc",       pc,          32'h0);
        check("rst_epc",      epc,         32'h0);
        check("rst_fv",       fetch_valid, 1'b0);
        check("rst_misalign", misalign,    1'b0);
        check("rst_halted",   halted,      1'b0);
        check("rst_pc_plus",  pc_plus,     32'h4);

        // Release reset; BOOT lasts one cycle.
        reset = 1'b0;
        step();
        check("boot_fv", fetch_valid, 1'b1);
        check("boot_pc", pc,          32'h0);
        step();
        check("seq_pc4", pc, 32'h4);
        step();
        check("seq_pc8", pc, 32'h8);

        // Memory not ready for three edges, then stall for two.
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("notready_hold", pc, 32'h8);
        end
        fetch_ready = 1'b1;
        stall       = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_hold", pc, 32'h8);
        end
        stall = 1'b0;
        step();
        check("seq_pcC", pc, 32'hC);

        // Aligned redirect overrides stall and not-ready.
        stall           = 1'b1;
        fetch_ready     = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        step();
        check("redir_pc",       pc,       32'h200);
        check("redir_pc_plus",  pc_plus,  32'h204);
        check("redir_misalign", misalign, 1'b0);

        // Misaligned redirect becomes a trap entry.
        redirect_target = 32'h202;
        step();
        check("mis_pc",       pc,       32'h100);
        check("mis_epc",      epc,      32'h202);
        check("mis_misalign", misalign, 1'b1);
        redirect_valid = 1'b0;
        step();
        check("mis_pulse_end", misalign, 1'b0);
        check("mis_pc_hold",   pc,       32'h100);

        // Trap wins over ret and redirect in the same cycle.
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        step();
        check("redir40_pc", pc, 32'h40);
        trap_valid      = 1'b1;
        ret_valid       = 1'b1;
        redirect_target = 32'h300;
        step();
        check("trap_pc",       pc,       32'h100);
        check("trap_epc",      epc,      32'h40);
        check("trap_misalign", misalign, 1'b0);
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        step();
        check("ret_pc",  pc,  32'h40);
        check("ret_epc", epc, 32'h40);
        ret_valid = 1'b0;

        // Halt at 0x10, redirect while halted, resume.
        stall           = 1'b0;
        fetch_ready     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h10;
        step();
        check("redir10_pc", pc, 32'h10);
        redirect_valid = 1'b0;
        halt_req       = 1'b1;
        step();
        check("halt_fv",     fetch_valid, 1'b0);
        check("halt_halted", halted,      1'b1);
        check("halt_pc",     pc,          32'h10);
        step();
        check("halt_hold_pc", pc,     32'h10);
        check("halt_stays",   halted, 1'b1);
        halt_req        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        step();
        check("halt_redir_pc", pc,          32'h80);
        check("halt_redir_fv", fetch_valid, 1'b0);
        redirect_valid = 1'b0;
        resume_req     = 1'b1;
        step();
        check("resume_fv",     fetch_valid, 1'b1);
        check("resume_halted", halted,      1'b0);
        check("resume_pc",     pc,          32'h80);
        resume_req = 1'b0;
        step();
        check("resume_adv", pc, 32'h84);

        // halt_req beats resume_req in RUN.
        halt_req   = 1'b1;
        resume_req = 1'b1;
        step();
        check("halt_prio_halted", halted, 1'b1);
        check("halt_prio_pc",     pc,     32'h84);
        halt_req = 1'b0;
        step();
        check("halt_prio_resume", fetch_valid, 1'b1);
        resume_req = 1'b0;

        // Asynchronous reset mid-stream.
        step();
        check("pre_areset_pc", pc, 32'h88);
        #2;
        reset = 1'b1;
        #1;
        check("areset_pc",     pc,          32'h0);
        check("areset_epc",    epc,         32'h0);
        check("areset_fv",     fetch_valid, 1'b0);
        check("areset_halted", halted,      1'b0);

        // Wrap-around with a high reset vector.
        step();
        reset_hv = 1'b0;
        step();
        check("hv_boot_fv", fetch_valid_hv, 1'b1);
        check("hv_pc0",     pc_hv,          32'hFFFF_FFF8);
        step();
        check("hv_pc1",      pc_hv,      32'hFFFF_FFFC);
        check("hv_pc_plus1", pc_plus_hv, 32'h0);
        step();
        check("hv_wrap", pc_hv, 32'h0);
        step();
        check("hv_after_wrap", pc_hv, 32'h4);
        #2;
        reset_hv = 1'b1;
        #1;
        check("hv_areset_pc", pc_hv,          32'hFFFF_FFF8);
        check("hv_areset_fv", fetch_valid_hv, 1'b0);
        check("hv_other_dut", pc,             32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
